ap_ctrl_perf_monitor: RTL
=========================

// Module: ap_ctrl_perf_monitor
// PURPOSE
//  Multi-channel, synthesizable performance monitor for ap_ctrl_hs/ap_ctrl_chain kernels.
//  Tracks the start/done/continue handshake of NUM_CH modules.
//  Keeps per-channel transaction count, last/min/max latency and an overflow flag.
//  Sits beside the kernel tops in the sim/verilog bench, or in on-chip debug, feeding the CSV dump flow.
// PARAMETERS
//  NUM_CH  4   number of monitored modules (1..16)
//  CNT_W   32  transaction-counter width
//  LAT_W   16  latency-counter width
// PORTS
//  clock        in   1                    system clock, rising edge
//  reset        in   1                    asynchronous, active-high; clears all state
//  ap_start     in   NUM_CH               per-channel ap_start
//  ap_done      in   NUM_CH               per-channel ap_done
//  ap_continue  in   NUM_CH               per-channel ap_continue; tie 1 for ap_ctrl_hs
//  finish       in   1                    freeze: all FSMs and counters hold while high
//  rd_ch        in   max(1,$clog2(NUM_CH)) channel select for readout
//  txn_cnt      out  CNT_W                completed transactions, selected channel
//  last_lat     out  LAT_W                latency of most recent transaction, selected channel
//  min_lat      out  LAT_W                minimum latency, selected channel
//  max_lat      out  LAT_W                maximum latency, selected channel
//  lat_ovf      out  NUM_CH               sticky: latency counter saturated
//  busy         out  NUM_CH               channel FSM not IDLE
//  all_idle     out  1                    &(~busy)
// BEHAVIOUR
//  Reset values:
//   - FSMs -> IDLE.
//   - Counters, last_lat, max_lat, txn_cnt, lat_ovf, busy -> 0.
//   - min_lat -> all-ones.
//   - all_idle -> 1.
//  Per-channel FSM (IDLE, RUN, WAITC):
//   - IDLE: ap_start=1 -> RUN; lat counter := 0.
//   - RUN: lat counter += 1 per cycle, saturating at all-ones.
//     - Reaching all-ones sets lat_ovf[ch], which stays set until reset.
//   - RUN & ap_done & ap_continue -> commit.
//   - RUN & ap_done & !ap_continue -> WAITC; the latency value is captured at the done cycle.
//   - WAITC: holds the captured latency; ap_continue=1 -> commit.
//   - Commit: next state is RUN (lat := 0) if ap_start=1 in the same cycle, else IDLE.
//  Latency definition:
//   - Latency = done cycle index minus start-accept cycle index.
//   - Done in the cycle after start gives 1.
//   - ap_done in the same cycle as start-accept in IDLE is ignored.
//  Commit actions, all in the same edge:
//   - txn_cnt += 1, saturating.
//   - last_lat := captured latency.
//   - min_lat := min(min_lat, lat).
//   - max_lat := max(max_lat, lat).
//  finish=1: no state or counter changes; handshake inputs are ignored during that cycle.
//  Readout:
//   - txn_cnt, last_lat, min_lat and max_lat are registered muxes.
//   - Valid one cycle after rd_ch changes.
//   - rd_ch >= NUM_CH -> all four read 0.
//  busy and all_idle are registered from FSM state: asserted the cycle after start-accept.
//  Reset asserted mid-transaction aborts it immediately; no commit occurs.
// CONFIGURATION
//  AP_MON_STALL_CNT_EN defined:
//   - Adds output stall_cnt [CNT_W] (selected channel, same registered mux).
//   - stall_cnt counts cycles spent in WAITC; saturating; reset 0; frozen by finish.
//  AP_MON_STALL_CNT_EN undefined: port and logic absent; WAITC behaviour unchanged.
// TESTING
//  1. Ch0: start pulse at T, done at T+5, continue=1 -> txn_cnt=1, last/min/max_lat=5, busy[0] high T+1..T+5.
//  2. Ch1: three transactions, latencies 3, 9, 4 -> txn_cnt=3, last_lat=4, min_lat=3, max_lat=9.
//  3. Ch2: done at lat=6 with continue=0 for 4 cycles, then continue=1 ->
//     last_lat=6 (not 10); stall_cnt=4 when AP_MON_STALL_CNT_EN is defined.
//  4. Ch3: LAT_W=4, done after 20 cycles -> last_lat=15, lat_ovf[3]=1, flag persists after further transactions.
//  5. Back-to-back: commit cycle with ap_start=1 -> FSM stays RUN, next latency counted from 0;
//     finish held 3 cycles mid-RUN -> latency excludes those 3 cycles.
//  6. Async reset during RUN on ch0 -> busy=0 and txn_cnt=0 without a clock edge;
//     min_lat reads all-ones; rd_ch=NUM_CH reads 0.

Source files
------------

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_hs/ap_ctrl_chain handshake monitor: transaction count, last/min/max latency.
// Define AP_MON_STALL_CNT_EN to add a per-channel counter of cycles spent waiting for ap_continue.
module ap_ctrl_perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LAT_W  = 16,
  localparam int unsigned RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic [RD_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [LAT_W-1:0]  last_lat,
  output logic [LAT_W-1:0]  min_lat,
  output logic [LAT_W-1:0]  max_lat,
  output logic [NUM_CH-1:0] lat_ovf,
  output logic [NUM_CH-1:0] busy,
  output logic              all_idle
`ifdef AP_MON_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StWaitc} state_e;

  localparam logic [LAT_W-1:0] LatMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NUM_CH-1:0][CNT_W-1:0] txn_all;
  logic [NUM_CH-1:0][LAT_W-1:0] last_all;
  logic [NUM_CH-1:0][LAT_W-1:0] min_all;
  logic [NUM_CH-1:0][LAT_W-1:0] max_all;
`ifdef AP_MON_STALL_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] stall_all;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] last_q;
    logic [LAT_W-1:0] min_q;
    logic [LAT_W-1:0] max_q;
    logic [CNT_W-1:0] txn_q;
    logic             busy_q;
    logic             ovf_q;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] commit_lat;
    logic             commit;

    // Latency of a done seen this cycle is the counter after this cycle's increment.
    assign lat_inc = (lat_q == LatMax) ? LatMax : lat_q + LAT_W'(1);

    always_comb begin
      commit     = 1'b0;
      commit_lat = lat_q;
      if (state_q == StRun && ap_done[c] && ap_continue[c]) begin
        commit     = 1'b1;
        commit_lat = lat_inc;
      end else if (state_q == StWaitc && ap_continue[c]) begin
        commit     = 1'b1;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        lat_q   <= '0;
        last_q  <= '0;
        min_q   <= '1;
        max_q   <= '0;
        txn_q   <= '0;
        busy_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (!finish) begin
        case (state_q)
          StIdle: begin
            if (ap_start[c]) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              lat_q   <= '0;
            end
          end
          StRun: begin
            lat_q <= lat_inc;
            if (lat_inc == LatMax) ovf_q <= 1'b1;
            if (ap_done[c] && !ap_continue[c]) state_q <= StWaitc;
          end
          StWaitc: begin
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
        // Commit overrides the per-state updates; a concurrent start is accepted back-to-back.
        if (commit) begin
          txn_q   <= (txn_q == CntMax) ? CntMax : txn_q + CNT_W'(1);
          last_q  <= commit_lat;
          if (commit_lat < min_q) min_q <= commit_lat;
          if (commit_lat > max_q) max_q <= commit_lat;
          lat_q   <= '0;
          state_q <= ap_start[c] ? StRun : StIdle;
          busy_q  <= ap_start[c];
        end
      end
    end

    assign txn_all[c]  = txn_q;
    assign last_all[c] = last_q;
    assign min_all[c]  = min_q;
    assign max_all[c]  = max_q;
    assign busy[c]     = busy_q;
    assign lat_ovf[c]  = ovf_q;

`ifdef AP_MON_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stall_q <= '0;
      end else if (!finish && state_q == StWaitc && stall_q != CntMax) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end

    assign stall_all[c] = stall_q;
`endif
  end

  assign all_idle = ~|busy;

  logic rd_valid;
  assign rd_valid = 32'(rd_ch) < NUM_CH;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_cnt  <= '0;
      last_lat <= '0;
      min_lat  <= '1;
      max_lat  <= '0;
    end else if (rd_valid) begin
      txn_cnt  <= txn_all[rd_ch];
      last_lat <= last_all[rd_ch];
      min_lat  <= min_all[rd_ch];
      max_lat  <= max_all[rd_ch];
    end else begin
      txn_cnt  <= '0;
      last_lat <= '0;
      min_lat  <= '0;
      max_lat  <= '0;
    end
  end

`ifdef AP_MON_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (rd_valid) begin
      stall_cnt <= stall_all[rd_ch];
    end else begin
      stall_cnt <= '0;
    end
  end
`endif

endmodule
